// File: rtl/shiftreg_digit.sv
// shiftreg_digit: digit-serial operand shifter, parallel load then DIGIT bits per enabled cycle
// Ports: clk, rst (sync, active-high); ena gates load/shift; clear zeroes all state regardless of ena;
//        load latches A and dir; sin back-fills the vacated digit on every shift;
//        digit_out is the current digit, valid/last/cnt track consumption, done pulses after the final digit.
module shiftreg_digit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ena,
  input  logic                               clear,
  input  logic                               load,
  input  logic                               dir,
  input  logic [WIDTH-1:0]                   A,
  input  logic [DIGIT-1:0]                   sin,
  output logic [DIGIT-1:0]                   digit_out,
  output logic                               valid,
  output logic                               last,
  output logic                               done,
  output logic [$clog2(WIDTH/DIGIT+1)-1:0]   cnt
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = $clog2(NDIG + 1);
  logic [WIDTH-1:0] reg_q, reg_d, shr, shl;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dir_q, dir_d, valid_q, valid_d, done_q, done_d;
  // A full-width digit leaves nothing of the old operand to keep.
  if (DIGIT == WIDTH) begin : g_full
    assign shr = sin;
    assign shl = sin;
  end else begin : g_part
    assign shr = {sin, reg_q[WIDTH-1:DIGIT]};
    assign shl = {reg_q[WIDTH-DIGIT-1:0], sin};
  end
  assign digit_out = dir_q ? reg_q[WIDTH-1 -: DIGIT] : reg_q[DIGIT-1:0];
  assign last = valid_q && (cnt_q == CW'(NDIG - 1));
  assign valid = valid_q;
  assign done = done_q;
  assign cnt = cnt_q;
  always_comb begin
    reg_d = reg_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    valid_d = valid_q;
    done_d = 1'b0;
    if (clear) begin
      reg_d = '0;
      dir_d = 1'b0;
      cnt_d = '0;
      valid_d = 1'b0;
    end else if (ena && load) begin
      reg_d = A;
      dir_d = dir;
      cnt_d = '0;
      valid_d = 1'b1;
    end else if (ena) begin
      reg_d = dir_q ? shl : shr;
      // Only shifts of a live operand count; idle shifting leaves cnt parked at NDIG.
      cnt_d = valid_q ? cnt_q + CW'(1) : cnt_q;
      valid_d = valid_q && !last;
      done_d = last;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q <= '0;
      dir_q <= 1'b0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      reg_q <= reg_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_shiftreg_digit.sv
// tb_shiftreg_digit: drives 8-bit instances with DIGIT=2, 1 and 8 against an arithmetic reference model
module tb_shiftreg_digit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, ena = 1'b0, clear = 1'b0, load = 1'b0, dir = 1'b0;
  logic [7:0] A = '0;
  logic [1:0] sin_a = '0;
  logic sin_b = 1'b0;
  logic [7:0] sin_c = '0;
  logic [1:0] dout_a;
  logic dout_b;
  logic [7:0] dout_c;
  logic valid_a, valid_b, valid_c, last_a, last_b, last_c, done_a, done_b, done_c;
  logic [2:0] cnt_a;
  logic [3:0] cnt_b;
  logic [0:0] cnt_c;
  shiftreg_digit #(.WIDTH(8), .DIGIT(2)) u_a (.clk(clk), .rst(rst), .ena(ena), .clear(clear), .load(load), .dir(dir), .A(A), .sin(sin_a), .digit_out(dout_a), .valid(valid_a), .last(last_a), .done(done_a), .cnt(cnt_a));
  shiftreg_digit #(.WIDTH(8), .DIGIT(1)) u_b (.clk(clk), .rst(rst), .ena(ena), .clear(clear), .load(load), .dir(dir), .A(A), .sin(sin_b), .digit_out(dout_b), .valid(valid_b), .last(last_b), .done(done_b), .cnt(cnt_b));
  shiftreg_digit #(.WIDTH(8), .DIGIT(8)) u_c (.clk(clk), .rst(rst), .ena(ena), .clear(clear), .load(load), .dir(dir), .A(A), .sin(sin_c), .digit_out(dout_c), .valid(valid_c), .last(last_c), .done(done_c), .cnt(cnt_c));
  int checks = 0, errors = 0;
  int dw[3] = '{2, 1, 8};
  int m_reg[3] = '{0, 0, 0}, m_dir[3] = '{0, 0, 0}, m_cnt[3] = '{0, 0, 0};
  int m_valid[3] = '{0, 0, 0}, m_done[3] = '{0, 0, 0};
  function automatic int obs_dig(int k);
    return k == 0 ? int'(dout_a) : k == 1 ? int'(dout_b) : int'(dout_c);
  endfunction
  function automatic int obs_valid(int k);
    return k == 0 ? int'(valid_a) : k == 1 ? int'(valid_b) : int'(valid_c);
  endfunction
  function automatic int obs_last(int k);
    return k == 0 ? int'(last_a) : k == 1 ? int'(last_b) : int'(last_c);
  endfunction
  function automatic int obs_done(int k);
    return k == 0 ? int'(done_a) : k == 1 ? int'(done_b) : int'(done_c);
  endfunction
  function automatic int obs_cnt(int k);
    return k == 0 ? int'(cnt_a) : k == 1 ? int'(cnt_b) : int'(cnt_c);
  endfunction
  function automatic int exp_dig(int k);
    return m_dir[k] != 0 ? m_reg[k] >> (8 - dw[k]) : m_reg[k] % (1 << dw[k]);
  endfunction
  function automatic int exp_last(int k);
    return (m_valid[k] != 0 && m_cnt[k] == 8 / dw[k] - 1) ? 1 : 0;
  endfunction
  // Operand treated as an integer: draining LSB-first divides by 2^D, MSB-first multiplies by 2^D modulo 256.
  function automatic void model_edge(int k, int s);
    int d = dw[k];
    m_done[k] = 0;
    if (rst || clear) begin
      m_reg[k] = 0; m_dir[k] = 0; m_cnt[k] = 0; m_valid[k] = 0;
    end else if (ena && load) begin
      m_reg[k] = int'(A); m_dir[k] = int'(dir); m_cnt[k] = 0; m_valid[k] = 1;
    end else if (ena) begin
      m_reg[k] = m_dir[k] != 0 ? (m_reg[k] * (1 << d) + s) % 256 : m_reg[k] / (1 << d) + s * (1 << (8 - d));
      if (m_valid[k] != 0) begin
        m_cnt[k]++;
        if (m_cnt[k] == 8 / d) begin
          m_valid[k] = 0;
          m_done[k] = 1;
        end
      end
    end
  endfunction
  task automatic cycle();
    model_edge(0, int'(sin_a));
    model_edge(1, int'(sin_b));
    model_edge(2, int'(sin_c));
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1; ena = 1; load = 1; A = 8'hFF;
    repeat (2) cycle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_dig(k) !== 0 || obs_valid(k) !== 0 || obs_cnt(k) !== 0 || obs_done(k) !== 0 || obs_last(k) !== 0) begin
        errors++;
        $display("FAIL reset[%0d]: dig=%0d valid=%0d cnt=%0d done=%0d last=%0d, all must be 0", k, obs_dig(k), obs_valid(k), obs_cnt(k), obs_done(k), obs_last(k));
      end
    end
    rst = 0;
    cycle();
    checks++;
    if (valid_a !== 1'b1 || dout_a !== 2'd3) begin
      errors++;
      $display("FAIL load_ff: valid=%0d dig=%0d, required 1/3", valid_a, dout_a);
    end
    load = 0; ena = 0; clear = 1;
    cycle();
    clear = 0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_dig(k) !== 0 || obs_valid(k) !== 0 || obs_cnt(k) !== 0 || obs_done(k) !== 0 || obs_last(k) !== 0) begin
        errors++;
        $display("FAIL clear[%0d]: dig=%0d valid=%0d cnt=%0d done=%0d last=%0d, all must be 0", k, obs_dig(k), obs_valid(k), obs_cnt(k), obs_done(k), obs_last(k));
      end
    end
  endtask
  task automatic test_lsb();
    int ed[4] = '{0, 1, 3, 2};
    ena = 1; load = 1; dir = 0; A = 8'hB4; sin_a = 0; sin_b = 0; sin_c = 0;
    cycle();
    load = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (int'(dout_a) !== ed[i] || int'(cnt_a) !== i || last_a !== (i == 3) || valid_a !== 1'b1 || done_a !== 1'b0) begin
        errors++;
        $display("FAIL lsb_digit[%0d]: dig=%0d cnt=%0d last=%0d valid=%0d, required %0d/%0d/%0d/1", i, dout_a, cnt_a, last_a, valid_a, ed[i], i, i == 3);
      end
      cycle();
    end
    checks++;
    if (done_a !== 1'b1 || valid_a !== 1'b0 || cnt_a !== 3'd4 || dout_a !== 2'd0 || last_a !== 1'b0) begin
      errors++;
      $display("FAIL lsb_end: done=%0d valid=%0d cnt=%0d dig=%0d, required 1/0/4/0", done_a, valid_a, cnt_a, dout_a);
    end
    cycle();
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL lsb_done_pulse: done=%0d, required 0", done_a);
    end
  endtask
  task automatic test_msb();
    int ed[4] = '{2, 3, 1, 0};
    ena = 1; load = 1; dir = 1; A = 8'hB4; sin_a = 2'b11;
    cycle();
    load = 0; dir = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (int'(dout_a) !== ed[i] || int'(cnt_a) !== i) begin
        errors++;
        $display("FAIL msb_digit[%0d]: dig=%0d cnt=%0d, required %0d/%0d", i, dout_a, cnt_a, ed[i], i);
      end
      cycle();
    end
    checks++;
    if (dout_a !== 2'd3 || valid_a !== 1'b0 || cnt_a !== 3'd4 || done_a !== 1'b1) begin
      errors++;
      $display("FAIL msb_fill: dig=%0d valid=%0d cnt=%0d done=%0d, required 3/0/4/1", dout_a, valid_a, cnt_a, done_a);
    end
    repeat (3) cycle();
    checks++;
    if (cnt_a !== 3'd4 || done_a !== 1'b0 || valid_a !== 1'b0 || dout_a !== 2'd3) begin
      errors++;
      $display("FAIL msb_saturate: cnt=%0d done=%0d valid=%0d dig=%0d, required 4/0/0/3", cnt_a, done_a, valid_a, dout_a);
    end
    sin_a = 0;
  endtask
  task automatic test_ena_gaps();
    int pat[8] = '{1, 0, 0, 1, 0, 1, 0, 1};
    int pd, pc, pulses;
    pulses = 0;
    ena = 1; load = 1; dir = 0; A = 8'hB4; sin_a = 0;
    cycle();
    load = 0;
    for (int i = 0; i < 10; i++) begin
      ena = i < 8 ? pat[i][0] : 1'b0;
      pd = int'(dout_a); pc = int'(cnt_a);
      cycle();
      pulses += int'(done_a);
      if (!ena) begin
        checks++;
        if (int'(dout_a) !== pd || int'(cnt_a) !== pc) begin
          errors++;
          $display("FAIL gap_frozen[%0d]: dig=%0d cnt=%0d, required %0d/%0d", i, dout_a, cnt_a, pd, pc);
        end
      end
      checks++;
      if (int'(dout_a) !== exp_dig(0) || int'(cnt_a) !== m_cnt[0] || int'(done_a) !== m_done[0] || int'(valid_a) !== m_valid[0]) begin
        errors++;
        $display("FAIL gap_model[%0d]: dig=%0d cnt=%0d done=%0d valid=%0d, required %0d/%0d/%0d/%0d", i, dout_a, cnt_a, done_a, valid_a, exp_dig(0), m_cnt[0], m_done[0], m_valid[0]);
      end
    end
    checks++;
    if (pulses !== 1 || cnt_a !== 3'd4) begin
      errors++;
      $display("FAIL gap_pulses: done pulses=%0d cnt=%0d, required 1/4", pulses, cnt_a);
    end
  endtask
  task automatic test_reload();
    ena = 1; load = 1; dir = 0; A = 8'hB4; sin_a = 0;
    cycle();
    load = 0;
    repeat (2) cycle();
    load = 1; A = 8'h1E;
    cycle();
    load = 0;
    checks++;
    if (dout_a !== 2'd2 || cnt_a !== 3'd0 || done_a !== 1'b0 || valid_a !== 1'b1) begin
      errors++;
      $display("FAIL reload: dig=%0d cnt=%0d done=%0d valid=%0d, required 2/0/0/1", dout_a, cnt_a, done_a, valid_a);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (int'(done_a) !== (i == 3) || int'(cnt_a) !== i + 1) begin
        errors++;
        $display("FAIL reload_drain[%0d]: done=%0d cnt=%0d, required %0d/%0d", i, done_a, cnt_a, i == 3, i + 1);
      end
    end
  endtask
  task automatic test_extremes();
    ena = 1; load = 1; dir = 0; A = 8'h01; sin_b = 0; sin_c = 0;
    cycle();
    load = 0;
    checks++;
    if (valid_c !== 1'b1 || last_c !== 1'b1 || dout_c !== 8'h01 || last_b !== 1'b0) begin
      errors++;
      $display("FAIL full_digit_load: valid_c=%0d last_c=%0d dig_c=%0d last_b=%0d, required 1/1/1/0", valid_c, last_c, dout_c, last_b);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (int'(dout_b) !== (i == 0) || int'(last_b) !== (i == 7)) begin
        errors++;
        $display("FAIL bit_digit[%0d]: dig=%0d last=%0d, required %0d/%0d", i, dout_b, last_b, i == 0, i == 7);
      end
      cycle();
      if (i == 0) begin
        checks++;
        if (done_c !== 1'b1 || valid_c !== 1'b0 || cnt_c !== 1'b1) begin
          errors++;
          $display("FAIL full_digit_done: done=%0d valid=%0d cnt=%0d, required 1/0/1", done_c, valid_c, cnt_c);
        end
      end
    end
    checks++;
    if (done_b !== 1'b1 || cnt_b !== 4'd8) begin
      errors++;
      $display("FAIL bit_done: done=%0d cnt=%0d, required 1/8", done_b, cnt_b);
    end
  endtask
  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      ena = 1; load = 1; dir = 1'($urandom_range(0, 1)); A = 8'($urandom);
      cycle();
      load = 0;
      repeat (4) cycle();
      checks++;
      if (done_a !== 1'b1 || valid_a !== 1'b0) begin
        errors++;
        $display("FAIL b2b_done[%0d]: done=%0d valid=%0d, required 1/0", n, done_a, valid_a);
      end
    end
    load = 1; A = 8'h5A; dir = 0;
    cycle();
    load = 0;
    checks++;
    if (valid_a !== 1'b1 || cnt_a !== 3'd0 || dout_a !== 2'd2 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reload: valid=%0d cnt=%0d dig=%0d done=%0d, required 1/0/2/0", valid_a, cnt_a, dout_a, done_a);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 59) == 0;
      clear = $urandom_range(0, 29) == 0;
      ena = $urandom_range(0, 3) != 0;
      load = $urandom_range(0, 6) == 0;
      dir = 1'($urandom_range(0, 1));
      A = 8'($urandom);
      sin_a = 2'($urandom);
      sin_b = 1'($urandom);
      sin_c = 8'($urandom);
      cycle();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_dig(k) !== exp_dig(k) || obs_valid(k) !== m_valid[k] || obs_last(k) !== exp_last(k) || obs_done(k) !== m_done[k] || obs_cnt(k) !== m_cnt[k]) begin
          errors++;
          $display("FAIL random[%0d/%0d]: dig=%0d valid=%0d last=%0d done=%0d cnt=%0d, required %0d/%0d/%0d/%0d/%0d", i, k, obs_dig(k), obs_valid(k), obs_last(k), obs_done(k), obs_cnt(k), exp_dig(k), m_valid[k], exp_last(k), m_done[k], m_cnt[k]);
        end
      end
    end
    rst = 0; clear = 0; load = 0;
  endtask
  initial begin
    test_reset();
    test_lsb();
    test_msb();
    test_ena_gaps();
    test_reload();
    test_extremes();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
